// File: rtl/bec_host_ctrl_if.sv
// Host and BEC-facing signal bundle for the BEC host controller.
// The controller connects through the slave modport; the environment
// (host plus BEC core) uses the master modport.
`timescale 1ns/1ps
interface bec_host_ctrl_if;
  // host side
  logic         host_wr;
  logic [5:0]   host_waddr;
  logic [31:0]  host_wdata;
  logic         host_start;
  logic [3:0]   host_raddr;
  logic [31:0]  host_rdata;
  logic         busy;
  logic         res_valid;
  // BEC side
  logic         bec_load_data;
  logic [2:0]   bec_load_status;
  logic [162:0] bec_data_in;
  logic         bec_trigLoad;
  logic         bec_ki;
  logic         bec_enable;
  logic         bec_next_key;
  logic [3:0]   bec_status;
  logic         bec_done;
  logic [162:0] bec_data_out;

  modport slave (
    input  host_wr, host_waddr, host_wdata, host_start, host_raddr,
    output host_rdata, busy, res_valid,
    output bec_load_data, bec_load_status, bec_data_in, bec_trigLoad,
    output bec_ki, bec_enable,
    input  bec_next_key, bec_status, bec_done, bec_data_out
  );

  modport master (
    output host_wr, host_waddr, host_wdata, host_start, host_raddr,
    input  host_rdata, busy, res_valid,
    input  bec_load_data, bec_load_status, bec_data_in, bec_trigLoad,
    input  bec_ki, bec_enable,
    output bec_next_key, bec_status, bec_done, bec_data_out
  );
endinterface

// File: rtl/bec_host_ctrl.sv
// BEC host controller: holds six 163-bit operands and a 163-bit key written
// 32 bits at a time by the host, loads them into the BEC core, streams the
// key bits MSB first while the core iterates, then reads back two results.
`timescale 1ns/1ps
module bec_host_ctrl (
  input  logic           clk,
  input  logic           rst,
  bec_host_ctrl_if.slave bus
);
  localparam int         DATA_W    = 163;
  localparam int         WORD_W    = 32;
  localparam int         EXT_W     = 6 * WORD_W;
  localparam int         NSLOT     = 7;
  localparam int         KEY_SLOT  = 6;
  localparam logic [7:0] KIDX_MAX  = 8'd162;
  localparam logic [2:0] LAST_CODE = 3'd5;
  localparam logic [2:0] MAX_WORD  = 3'd5;
  localparam logic [2:0] BAD_SLOT  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_LOAD, S_ENA, S_RUN, S_RDA, S_RDB, S_WIDLE
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   opr_q [NSLOT];
  logic [DATA_W-1:0]   key_q;
  logic [DATA_W-1:0]   res_a_q, res_b_q;
  logic [2:0]          ld_code_q;
  logic [7:0]          kidx_q;
  logic [7:0]          pulse_cnt;
  logic                res_valid_q;

  logic [2:0]          wr_slot, wr_word;
  logic                wr_en;
  logic [7:0]          ki_pos;
  logic                key_bit;
  logic                busy;

  logic                load_data, trig_load, enable, ki;
  logic [2:0]          load_status;
  logic [DATA_W-1:0]   data_in;
  logic [DATA_W-1:0]   res_sel;
  logic                unused_status;

  // Replace one 32-bit word of a 163-bit value; word 5 keeps only bits [2:0].
  function automatic logic [DATA_W-1:0] put_word(input logic [DATA_W-1:0] old,
                                                 input logic [2:0] w,
                                                 input logic [WORD_W-1:0] d);
    logic [EXT_W-1:0] ext;
    ext = {{(EXT_W-DATA_W){1'b0}}, old};
    case (w)
      3'd0:    ext[31:0]    = d;
      3'd1:    ext[63:32]   = d;
      3'd2:    ext[95:64]   = d;
      3'd3:    ext[127:96]  = d;
      3'd4:    ext[159:128] = d;
      3'd5:    ext[191:160] = d;
      default: ;
    endcase
    return ext[DATA_W-1:0];
  endfunction

  // Extract one 32-bit word, zero-extended above bit 162 and zero for words 6-7.
  function automatic logic [WORD_W-1:0] get_word(input logic [DATA_W-1:0] v,
                                                 input logic [2:0] w);
    logic [EXT_W-1:0]  ext;
    logic [WORD_W-1:0] r;
    ext = {{(EXT_W-DATA_W){1'b0}}, v};
    r   = '0;
    case (w)
      3'd0:    r = ext[31:0];
      3'd1:    r = ext[63:32];
      3'd2:    r = ext[95:64];
      3'd3:    r = ext[127:96];
      3'd4:    r = ext[159:128];
      3'd5:    r = ext[191:160];
      default: r = '0;
    endcase
    return r;
  endfunction

  assign wr_slot = bus.host_waddr[5:3];
  assign wr_word = bus.host_waddr[2:0];
  assign busy    = (state != S_IDLE);
  // Writes are frozen while a sequence owns the slots.
  assign wr_en   = bus.host_wr && !busy && (wr_slot != BAD_SLOT) && (wr_word <= MAX_WORD);

  assign key_q   = opr_q[KEY_SLOT];
  assign ki_pos  = KIDX_MAX - kidx_q;
  assign key_bit = key_q[ki_pos];

  // Operand and key storage, written word by word by the host.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) opr_q[i] <= '0;
    end else if (wr_en) begin
      opr_q[wr_slot] <= put_word(opr_q[wr_slot], wr_word, bus.host_wdata);
    end
  end

  // State register plus sequence counters and the result-valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ld_code_q   <= '0;
      kidx_q      <= '0;
      pulse_cnt   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (bus.host_start) begin
            res_valid_q <= 1'b0;
            ld_code_q   <= '0;
            kidx_q      <= '0;
            pulse_cnt   <= '0;
          end
        end
        S_LOAD: ld_code_q <= ld_code_q + 3'd1;
        S_RUN: begin
          if (bus.bec_next_key) begin
            pulse_cnt <= pulse_cnt + 8'd1;
            if (kidx_q != KIDX_MAX) kidx_q <= kidx_q + 8'd1;
          end
        end
        S_WIDLE: begin
          if (bus.bec_status[3]) res_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result capture at the end of the two readback cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_a_q <= '0;
      res_b_q <= '0;
    end else begin
      if (state == S_RDA) res_a_q <= bus.bec_data_out;
      if (state == S_RDB) res_b_q <= bus.bec_data_out;
    end
  end

  // Next state and BEC-side outputs; every output idles at zero by default.
  always_comb begin
    state_nxt   = state;
    load_data   = 1'b0;
    trig_load   = 1'b0;
    enable      = 1'b0;
    ki          = 1'b0;
    load_status = 3'd0;
    data_in     = '0;
    case (state)
      S_IDLE: begin
        if (bus.host_start) state_nxt = S_REQ;
      end
      S_REQ: begin
        load_data = 1'b1;
        ki        = key_q[KIDX_MAX];
        if (bus.bec_status[2]) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // The core routes each loaded operand by ki, so hold the key MSB.
        trig_load   = 1'b1;
        load_status = ld_code_q;
        data_in     = opr_q[ld_code_q];
        ki          = key_q[KIDX_MAX];
        if (ld_code_q == LAST_CODE) state_nxt = S_ENA;
      end
      S_ENA: begin
        enable = 1'b1;
        ki     = key_bit;
        if (bus.bec_status[1]) state_nxt = S_RUN;
      end
      S_RUN: begin
        ki = key_bit;
        if (bus.bec_done) state_nxt = S_RDA;
      end
      S_RDA: begin
        load_status = 3'd0;
        state_nxt   = S_RDB;
      end
      S_RDB: begin
        // Code 001 also tells the core to drop back to idle.
        load_status = 3'd1;
        state_nxt   = S_WIDLE;
      end
      S_WIDLE: begin
        if (bus.bec_status[3]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign res_sel = bus.host_raddr[3] ? res_b_q : res_a_q;

  assign bus.host_rdata      = get_word(res_sel, bus.host_raddr[2:0]);
  assign bus.busy            = busy;
  assign bus.res_valid       = res_valid_q;
  assign bus.bec_load_data   = load_data;
  assign bus.bec_load_status = load_status;
  assign bus.bec_data_in     = data_in;
  assign bus.bec_trigLoad    = trig_load;
  assign bus.bec_ki          = ki;
  assign bus.bec_enable      = enable;

  // The upload flag is implied by bec_done, which is what the sequence uses.
  assign unused_status = bus.bec_status[0];
endmodule

// File: tb/tb_bec_host_ctrl.sv
// Testbench for bec_host_ctrl: a behavioural host plus BEC core drive the
// controller with random operands, keys, handshake delays and results.
`timescale 1ns/1ps
module tb_bec_host_ctrl;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_miscmp;

  bec_host_ctrl_if bus ();

  bec_host_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model state
  logic [162:0] m_op [7];
  logic [162:0] m_cap_a, m_cap_b;
  logic [162:0] m_res_a, m_res_b;
  bit           m_busy;
  bit           m_rv;
  bit           upl_on;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BEC core model: result bus answers the readback code while uploading.
  always_comb begin
    bus.bec_data_out = '0;
    if (upl_on && bus.bec_load_status == 3'd0)      bus.bec_data_out = m_res_a;
    else if (upl_on && bus.bec_load_status == 3'd1) bus.bec_data_out = m_res_b;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [162:0] rand163();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[162:0];
  endfunction

  function automatic logic [31:0] exp_word(input logic [162:0] v, input int w);
    logic [31:0] r;
    r = '0;
    if (w <= 5)
      for (int b = 0; b < 32; b++)
        if (32 * w + b < 163) r[b] = v[32 * w + b];
    return r;
  endfunction

  task automatic model_write(input int s, input int w, input logic [31:0] d);
    if (!m_busy && s <= 6 && w <= 5)
      for (int b = 0; b < 32; b++)
        if (32 * w + b < 163) m_op[s][32 * w + b] = d[b];
  endtask

  task automatic host_write(input int s, input int w, input logic [31:0] d);
    logic [2:0] s3, w3;
    s3 = s[2:0];
    w3 = w[2:0];
    bus.host_wr    = 1'b1;
    bus.host_waddr = {s3, w3};
    bus.host_wdata = d;
    model_write(s, w, d);
    step();
    bus.host_wr = 1'b0;
  endtask

  task automatic check_bec_idle(input string tag);
    chk_eq({tag, "_load_data"}, bus.bec_load_data, 1'b0);
    chk_eq({tag, "_load_status"}, bus.bec_load_status, 3'd0);
    chk_eq({tag, "_data_in"}, bus.bec_data_in, 163'd0);
    chk_eq({tag, "_trig"}, bus.bec_trigLoad, 1'b0);
    chk_eq({tag, "_ki"}, bus.bec_ki, 1'b0);
    chk_eq({tag, "_enable"}, bus.bec_enable, 1'b0);
  endtask

  task automatic check_readback(input string tag);
    logic [3:0] a;
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 8; w++) begin
        a = {s[0], w[2:0]};
        bus.host_raddr = a;
        step();
        chk_eq(tag, bus.host_rdata, exp_word((s == 1) ? m_cap_b : m_cap_a, w));
      end
  endtask

  task automatic bec_inputs_idle();
    bus.bec_next_key = 1'b0;
    bus.bec_status   = 4'b1000;
    bus.bec_done     = 1'b0;
    upl_on           = 1'b0;
  endtask

  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    chk_eq("rst_busy", bus.busy, 1'b0);
    chk_eq("rst_res_valid", bus.res_valid, 1'b0);
    for (int s = 0; s < 7; s++) m_op[s] = '0;
    m_cap_a = '0;
    m_cap_b = '0;
    m_busy  = 1'b0;
    m_rv    = 1'b0;
    bec_inputs_idle();
    check_bec_idle("rst_mid");
    step();
    rst = 1'b0;
    step();
    chk_eq("rst_pulse_cnt", dut.pulse_cnt, 8'd0);
  endtask

  // One full sequence from start pulse to results valid (or an early reset).
  task automatic run_txn(input int dl_dly, input int pr_dly, input int npulse, input int up_dly,
                         input logic [162:0] ra, input logic [162:0] rb,
                         input bit co_write, input bit meddle, input int rst_at);
    int cs, cw, kpos, gap;
    logic [31:0] cd;
    logic [2:0]  cs3, cw3;
    bus.host_start = 1'b1;
    if (co_write) begin
      cs  = $urandom_range(0, 6);
      cw  = $urandom_range(0, 5);
      cd  = $urandom;
      cs3 = cs[2:0];
      cw3 = cw[2:0];
      bus.host_wr    = 1'b1;
      bus.host_waddr = {cs3, cw3};
      bus.host_wdata = cd;
      model_write(cs, cw, cd);
    end
    step();
    bus.host_start = 1'b0;
    bus.host_wr    = 1'b0;
    m_busy = 1'b1;
    m_rv   = 1'b0;
    chk_eq("start_busy", bus.busy, 1'b1);
    chk_eq("start_res_valid", bus.res_valid, 1'b0);
    chk_eq("req_ki", bus.bec_ki, m_op[6][162]);
    bus.bec_status = 4'b0000;
    for (int d = 0; d < dl_dly; d++) begin
      chk_eq("req_load_data", bus.bec_load_data, 1'b1);
      chk_eq("req_no_trig", bus.bec_trigLoad, 1'b0);
      step();
    end
    chk_eq("req_load_data", bus.bec_load_data, 1'b1);
    bus.bec_status = 4'b0100;
    step();
    for (int c = 0; c < 6; c++) begin
      chk_eq("load_trig", bus.bec_trigLoad, 1'b1);
      chk_eq("load_code", bus.bec_load_status, c[2:0]);
      chk_eq("load_data_in", bus.bec_data_in, m_op[c]);
      chk_eq("load_ki", bus.bec_ki, m_op[6][162]);
      chk_eq("load_no_req", bus.bec_load_data, 1'b0);
      step();
    end
    bus.bec_status = 4'b0000;
    chk_eq("ena_trig_off", bus.bec_trigLoad, 1'b0);
    chk_eq("ena_data_in", bus.bec_data_in, 163'd0);
    for (int d = 0; d < pr_dly; d++) begin
      chk_eq("ena_enable", bus.bec_enable, 1'b1);
      step();
    end
    chk_eq("ena_enable", bus.bec_enable, 1'b1);
    bus.bec_status = 4'b0010;
    step();
    chk_eq("run_enable_off", bus.bec_enable, 1'b0);
    chk_eq("run_load_status", bus.bec_load_status, 3'd0);
    for (int i = 0; i < npulse; i++) begin
      kpos = (i > 162) ? 0 : 162 - i;
      chk_eq("run_ki", bus.bec_ki, m_op[6][kpos]);
      if (rst_at == i) begin
        reset_mid();
        return;
      end
      bus.bec_next_key = 1'b1;
      step();
      bus.bec_next_key = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) step();
      if (meddle && i == 0) begin
        host_write(2, $urandom_range(0, 5), $urandom);
        bus.host_start = 1'b1;
        step();
        bus.host_start = 1'b0;
        chk_eq("restart_busy", bus.busy, 1'b1);
        chk_eq("restart_no_req", bus.bec_load_data, 1'b0);
        chk_eq("restart_no_trig", bus.bec_trigLoad, 1'b0);
      end
    end
    kpos = (npulse > 162) ? 0 : 162 - npulse;
    chk_eq("run_ki_end", bus.bec_ki, m_op[6][kpos]);
    chk_eq("pulse_cnt", dut.pulse_cnt, npulse % 256);
    m_res_a = ra;
    m_res_b = rb;
    upl_on  = 1'b1;
    bus.bec_done   = 1'b1;
    bus.bec_status = 4'b0001;
    step();
    chk_eq("rda_code", bus.bec_load_status, 3'd0);
    chk_eq("rda_trig", bus.bec_trigLoad, 1'b0);
    chk_eq("rda_busy", bus.busy, 1'b1);
    step();
    chk_eq("rdb_code", bus.bec_load_status, 3'd1);
    chk_eq("rdb_trig", bus.bec_trigLoad, 1'b0);
    step();
    upl_on         = 1'b0;
    bus.bec_done   = 1'b0;
    bus.bec_status = 4'b0000;
    chk_eq("widle_code", bus.bec_load_status, 3'd0);
    for (int d = 0; d < up_dly; d++) begin
      chk_eq("widle_busy", bus.busy, 1'b1);
      chk_eq("widle_res_valid", bus.res_valid, 1'b0);
      step();
    end
    bus.bec_status = 4'b1000;
    step();
    m_busy  = 1'b0;
    m_rv    = 1'b1;
    m_cap_a = ra;
    m_cap_b = rb;
    chk_eq("done_busy", bus.busy, 1'b0);
    chk_eq("done_res_valid", bus.res_valid, m_rv);
    check_bec_idle("done");
  endtask

  task automatic random_writes(input int n);
    for (int k = 0; k < n; k++)
      host_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom);
  endtask

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    m_busy   = 1'b0;
    m_rv     = 1'b0;
    m_res_a  = '0;
    m_res_b  = '0;
    m_cap_a  = '0;
    m_cap_b  = '0;
    for (int s = 0; s < 7; s++) m_op[s] = '0;
    bus.host_wr    = 1'b0;
    bus.host_waddr = '0;
    bus.host_wdata = '0;
    bus.host_start = 1'b0;
    bus.host_raddr = '0;
    bec_inputs_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    chk_eq("reset_busy", bus.busy, 1'b0);
    chk_eq("reset_res_valid", bus.res_valid, 1'b0);
    check_bec_idle("reset");
    check_readback("reset_rdata");

    // slot0 word0 = 1, key all ones, slow download flag, fixed results
    host_write(0, 0, 32'h1);
    for (int w = 0; w < 6; w++) host_write(6, w, 32'hFFFF_FFFF);
    run_txn(5, 1, 3, 1, 163'h5A5A, 163'h3C3C, 1'b0, 1'b0, -1);
    check_readback("rdata_fixed");

    // key MSB only, full 163 iterations
    for (int w = 0; w < 5; w++) host_write(6, w, 32'h0);
    host_write(6, 5, 32'h4);
    run_txn(0, 0, 163, 2, rand163(), rand163(), 1'b0, 1'b0, -1);
    check_readback("rdata_long");

    // writes and restart attempts while busy are ignored
    random_writes(20);
    run_txn(2, 2, 10, 0, rand163(), rand163(), 1'b0, 1'b1, -1);
    check_readback("rdata_meddle");

    // randomized sequences
    for (int t = 0; t < 6; t++) begin
      random_writes(12);
      run_txn($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 200),
              $urandom_range(0, 3), rand163(), rand163(), $urandom_range(0, 1) == 1,
              1'b0, -1);
      check_readback("rdata_rand");
    end

    // reset in the middle of RUN
    random_writes(10);
    run_txn(1, 1, 20, 1, rand163(), rand163(), 1'b0, 1'b0, 4);
    chk_eq("post_rst_busy", bus.busy, 1'b0);
    chk_eq("post_rst_res_valid", bus.res_valid, 1'b0);
    check_readback("rdata_post_rst");

    // normal operation resumes after the reset
    random_writes(14);
    run_txn(3, 2, 30, 1, rand163(), rand163(), 1'b1, 1'b0, -1);
    check_readback("rdata_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
